// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
//   ST_IDLE / ST_RUN / ST_DONE : FSM state encoding
//   clog2_min1()               : ceil(log2(v)), never less than 1 bit
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width helper; a 1-bit counter is kept even for WIDTH=1 so the
  // cnt vector never collapses to zero width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Full_Adder: single-bit full adder cell, purely combinational.
//   a, b, ci : operand bits and carry-in
//   s        : sum bit
//   co       : carry-out
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder computing a + b + ci over WIDTH
// cycles with one time-multiplexed Full_Adder cell.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, ci sampled on accept)
//   out_valid/out_ready  : result handshake (s, co, ovf)
//   s                    : sum modulo 2^WIDTH
//   co                   : unsigned carry-out
//   ovf                  : signed two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CNT_W = clog2_min1(WIDTH);

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
  logic [CNT_W-1:0] cnt;
  logic             carry_q, co_q, ovf_q;
  logic             fa_s, fa_co;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

  Full_Adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at sum_sh[0].
  generate
    if (WIDTH == 1) begin : g_sum1
      assign sum_next = fa_s;
    end else begin : g_sumn
      assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (cnt_last)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= ci;
            cnt     <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= sum_next;
          carry_q <= fa_co;
          cnt     <= cnt + CNT_W'(1);
          if (cnt_last) begin
            co_q  <= fa_co;
            // carry_q here is the carry into the MSB
            ovf_q <= carry_q ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign s   = sum_sh;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder at WIDTH 8, 4 and 1,
// compared against an integer-arithmetic reference of a + b + ci.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, ci8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, ci4, co4, ovf4;
  logic [3:0] a4, b4, s4;
  logic       iv1, ir1, ov1, or1, ci1, co1, ovf1;
  logic [0:0] a1, b1, s1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .ci(ci8), .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8));
  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .ci(ci4), .out_valid(ov4), .out_ready(or4), .s(s4), .co(co4), .ovf(ovf4));
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .ci(ci1), .out_valid(ov1), .out_ready(or1), .s(s1), .co(co1), .ovf(ovf1));

  int errors = 0;
  int checks = 0;

  // Returns {ovf, co, s[7:0]} for a w-bit add, from plain integer math.
  function automatic logic [9:0] ref_add(input int w, input int av, input int bv, input int civ);
    int m, sum, sa, sb, ss;
    logic [7:0] sv;
    logic cov, ov;
    m   = 1 << w;
    sum = av + bv + civ;
    sa  = (av >= m / 2) ? av - m : av;
    sb  = (bv >= m / 2) ? bv - m : bv;
    ss  = sa + sb + civ;
    sv  = 8'(sum % m);
    cov = (sum >= m);
    ov  = (ss > m / 2 - 1) || (ss < -(m / 2));
    return {ov, cov, sv};
  endfunction

  // Issues one WIDTH=8 operation; scrambles inputs while it runs.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic civ,
                     output logic [7:0] rs, output logic rco, output logic rovf,
                     output int lat);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    iv8 = 1'b1; a8 = av; b8 = bv; ci8 = civ;
    @(posedge clk); #1;
    lat = 0;
    while (!ov8 && lat < 100) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    iv8 = 1'b0;
    rs = s8; rco = co8; rovf = ovf8;
  endtask

  task automatic test_reset();
    iv8 = 0; iv4 = 0; iv1 = 0; or8 = 1; or4 = 1; or1 = 1;
    a8 = 0; b8 = 0; ci8 = 0; a4 = 0; b4 = 0; ci4 = 0; a1 = 0; b1 = 0; ci1 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s8 !== 8'h00 || co8 !== 1'b0 || ovf8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: s=%h co=%b ovf=%b ov=%b, want 00 0 0 0", s8, co8, ovf8, ov8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || ir4 !== 1'b1 || ir1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ir8=%b ov8=%b ir4=%b ir1=%b, want 1 0 1 1", ir8, ov8, ir4, ir1);
    end
  endtask

  task automatic test_directed();
    logic [7:0] rs; logic rco, rovf; int lat;
    or8 = 1'b1;
    op8(8'h5A, 8'h3C, 1'b0, rs, rco, rovf, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL latency_5a3c: got %0d want 8", lat); end
    checks++;
    if (rs !== 8'h96 || rco !== 1'b0 || rovf !== 1'b1) begin
      errors++; $display("FAIL add_5a3c: s=%h co=%b ovf=%b, want 96 0 1", rs, rco, rovf);
    end
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h96) begin
      errors++; $display("FAIL handshake_out: ir=%b ov=%b s=%h, want 1 0 96", ir8, ov8, s8);
    end
    op8(8'hFF, 8'h01, 1'b0, rs, rco, rovf, lat);
    checks++;
    if (rs !== 8'h00 || rco !== 1'b1 || rovf !== 1'b0) begin
      errors++; $display("FAIL add_ff01: s=%h co=%b ovf=%b, want 00 1 0", rs, rco, rovf);
    end
    @(posedge clk); #1;
    op8(8'h7F, 8'h00, 1'b1, rs, rco, rovf, lat);
    checks++;
    if (rs !== 8'h80 || rco !== 1'b0 || rovf !== 1'b1) begin
      errors++; $display("FAIL add_7f00c: s=%h co=%b ovf=%b, want 80 0 1", rs, rco, rovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] rs, av, bv; logic rco, rovf, cv; logic [9:0] e; int lat;
    or8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
      e = ref_add(8, int'(av), int'(bv), int'(cv));
      op8(av, bv, cv, rs, rco, rovf, lat);
      checks++;
      if (rs !== e[7:0] || rco !== e[8] || rovf !== e[9] || lat !== 8) begin
        errors++;
        $display("FAIL random8 %h+%h+%b: s=%h co=%b ovf=%b lat=%0d, want %h %b %b 8",
                 av, bv, cv, rs, rco, rovf, lat, e[7:0], e[8], e[9]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rs; logic rco, rovf; logic [9:0] e; int lat;
    or8 = 1'b0;
    e = ref_add(8, 8'hC3, 8'hA5, 1);
    op8(8'hC3, 8'hA5, 1'b1, rs, rco, rovf, lat);
    checks++;
    if (rs !== e[7:0] || rco !== e[8] || rovf !== e[9]) begin
      errors++; $display("FAIL bp_result: s=%h co=%b ovf=%b, want %h %b %b", rs, rco, rovf, e[7:0], e[8], e[9]);
    end
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (s8 !== rs || co8 !== rco || ovf8 !== rovf || ov8 !== 1'b1 || ir8 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: s=%h co=%b ovf=%b ov=%b ir=%b, want %h %b %b 1 0",
                 i, s8, co8, ovf8, ov8, ir8, rs, rco, rovf);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || s8 !== rs || co8 !== rco || ovf8 !== rovf) begin
      errors++; $display("FAIL bp_release: ov=%b ir=%b s=%h, want 0 1 %h", ov8, ir8, s8, rs);
    end
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++; $display("FAIL bp_idle: ir=%b ov=%b, want 1 0", ir8, ov8);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rs; logic rco, rovf; int lat;
    or8 = 1'b1;
    iv8 = 1'b1; a8 = 8'hE7; b8 = 8'h9B; ci8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (s8 !== 8'h00 || co8 !== 1'b0 || ovf8 !== 1'b0 || ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: s=%h co=%b ovf=%b ov=%b ir=%b, want 00 0 0 0 1", s8, co8, ovf8, ov8, ir8);
    end
    op8(8'h01, 8'h01, 1'b0, rs, rco, rovf, lat);
    checks++;
    if (rs !== 8'h02 || rco !== 1'b0 || rovf !== 1'b0 || lat !== 8) begin
      errors++; $display("FAIL after_reset: s=%h co=%b ovf=%b lat=%0d, want 02 0 0 8", rs, rco, rovf, lat);
    end
    @(posedge clk); #1;
  endtask

  // Back-to-back: in_valid held high, every a/b/ci combination.
  task automatic test_exhaustive_w4();
    logic [9:0] e; int lat, n, bad;
    bad = 0; or4 = 1'b1;
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          n = 0;
          while (!ir4 && n < 20) begin @(posedge clk); #1; n++; end
          a4 = 4'(av); b4 = 4'(bv); ci4 = 1'(cv); iv4 = 1'b1;
          e = ref_add(4, av, bv, cv);
          @(posedge clk); #1;
          a4 = ~a4; b4 = ~b4; ci4 = ~ci4;
          lat = 0;
          while (!ov4 && lat < 20) begin @(posedge clk); #1; lat++; end
          checks++;
          if (s4 !== e[3:0] || co4 !== e[8] || ovf4 !== e[9] || lat !== 4 || (av + bv + cv > 0 && n !== 1)) begin
            errors++; bad++;
            if (bad < 10)
              $display("FAIL w4 %0d+%0d+%0d: s=%h co=%b ovf=%b lat=%0d gap=%0d, want %h %b %b 4 1",
                       av, bv, cv, s4, co4, ovf4, lat, n, e[3:0], e[8], e[9]);
          end
        end
    iv4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive_w1();
    logic [9:0] e; int lat, n;
    or1 = 1'b1;
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int cv = 0; cv < 2; cv++) begin
          n = 0;
          while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
          a1 = 1'(av); b1 = 1'(bv); ci1 = 1'(cv); iv1 = 1'b1;
          e = ref_add(1, av, bv, cv);
          @(posedge clk); #1;
          a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
          lat = 0;
          while (!ov1 && lat < 20) begin @(posedge clk); #1; lat++; end
          checks++;
          if (s1 !== e[0:0] || co1 !== e[8] || ovf1 !== e[9] || lat !== 1) begin
            errors++;
            $display("FAIL w1 %0d+%0d+%0d: s=%b co=%b ovf=%b lat=%0d, want %b %b %b 1",
                     av, bv, cv, s1, co1, ovf1, lat, e[0], e[8], e[9]);
          end
        end
    iv1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive_w4();
    test_exhaustive_w1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder of two WIDTH-bit operands plus carry-in.
- One Full_Adder cell is time-multiplexed across WIDTH cycles; a carry flip-flop links the bits.
- Sits upstream of datapath consumers as the area-cheap alternative to a ripple-carry array.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b, ci are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in
- out_valid  output  1  s, co, ovf are valid
- out_ready  input  1  consumer accepts the result
- s  output  WIDTH  sum bits (a + b + ci), modulo 2^WIDTH
- co  output  1  unsigned carry-out
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset and clocking:
  - Reset is sampled only on the rising edge of clk while rst_n = 0.
  - On reset, the state goes to IDLE; s = 0, co = 0, ovf = 0, out_valid = 0; internal count, shift registers and carry clear.
  - in_ready = 1 in the first cycle after reset release.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On an edge with in_valid = 1, the block captures a and b into shift registers, carry_q <= ci, cnt <= 0, and moves to RUN.
- RUN:
  - in_ready = 0 and out_valid = 0.
  - Each edge feeds a_sh[0], b_sh[0] and carry_q to the Full_Adder.
  - Its sum bit shifts into the sum register at the MSB end; a_sh and b_sh shift right by one; carry_q <= the cell's co; cnt increments.
  - On the edge where cnt = WIDTH-1:
    - co <= the cell's co.
    - ovf <= carry_q XOR the cell's co. This is the carry into the MSB XOR the carry out of the MSB.
    - The state moves to DONE.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - s, co and ovf are held stable.
  - On an edge with out_ready = 1, the state moves to IDLE. s, co and ovf keep their values; only out_valid deasserts.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum issue interval is WIDTH + 2 cycles (accept, WIDTH RUN edges, handshake out).
- Operands are sampled only at the accepting edge. Changes on a, b or ci afterwards have no effect.
- in_valid during RUN or DONE is ignored, with no capture and no error. The upstream must hold in_valid until in_ready.
- out_ready while not in DONE has no effect.
- Reset mid-operation (RUN or DONE) aborts immediately. No partial result is presented and the state returns to IDLE.
- WIDTH = 1:
  - The block takes a single RUN cycle.
  - ovf = ci XOR co.
- cnt width is clog2(WIDTH), with a minimum of 1 bit.
- in_ready and out_valid are decoded directly from state registers, with no combinational path from inputs.

Decomposition:
- Shared package serial_adder_pkg holds:
  - State encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - A clog2 helper function.
- Sub-module: a single instance of the existing Full_Adder cell (ports a, b, ci, s, co) for the per-bit arithmetic. No other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, ci=0, out_ready=1 → out_valid 8 edges after accept; s=0x96, co=0, ovf=1; in_ready back to 1 two cycles later.
- WIDTH=8, a=0xFF, b=0x01, ci=0 → s=0x00, co=1, ovf=0. Then a=0x7F, b=0x00, ci=1 → s=0x80, co=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggle a/b/in_valid meanwhile → s, co, ovf and out_valid stay constant and in_ready=0. Raising out_ready gives one handshake, then IDLE.
- Reset mid-RUN: drive rst_n=0 at the 3rd RUN edge → next cycle in IDLE with s=0, co=0, ovf=0, out_valid=0, in_ready=1. A fresh 0x01+0x01 then yields 0x02.
- Operand stability: change a/b/ci every cycle after accept → result equals the values sampled at the accepting edge.
- WIDTH=4 exhaustive (all a, b, ci, 512 cases) and WIDTH=1 exhaustive → s, co, ovf match a reference model; latency = WIDTH every transaction, back-to-back in_valid held high.
